// File: rtl/serial_add32_ctrl_pkg.sv
// Shared constants and state encoding for the byte-serial add/subtract engine.
package serial_add32_ctrl_pkg;

  localparam int BYTE_W = 8;

  // Controller states; the unused code 2'd3 falls back to IDLE in the FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the byte index: clog2(n), never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_add32_ctrl_add8bit.sv
// 8-bit ripple-carry adder: the single shared datapath slice of the engine.
// o_overflow is the carry into bit 7 XOR the carry out of bit 7.
module add8bit (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout,
  output logic       o_overflow
);

  // Ripple the carry through eight full-adder cells.
  always_comb begin
    logic [8:0] c;
    c     = '0;
    o_sum = '0;
    c[0]  = i_cin;
    for (int k = 0; k < 8; k++) begin
      o_sum[k] = i_a[k] ^ i_b[k] ^ c[k];
      c[k+1]   = (i_a[k] & i_b[k]) | (c[k] & (i_a[k] ^ i_b[k]));
    end
    o_cout     = c[8];
    o_overflow = c[7] ^ c[8];
  end

endmodule

// File: rtl/serial_add32_ctrl.sv
// Byte-serial multi-precision add/subtract controller. One add8bit is reused
// for N_BYTES cycles, least significant byte first, with the carry held in a
// register between slices.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE and out_valid only in DONE, and
// neither depends combinationally on the partner's signal. Once out_valid is
// high, result/cout/overflow stay stable until the out_ready transfer.
module serial_add32_ctrl
  import serial_add32_ctrl_pkg::*;
#(
  parameter int N_BYTES = 4,
  parameter int W       = BYTE_W * N_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow,
  output logic         busy,
  output state_e       dbg_state
);

  localparam int            IW       = idx_w(N_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_result;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic          r_cout;
  logic          r_ovf;

  logic          w_accept;
  logic          w_step;
  logic          w_last;
  logic [7:0]    w_a_byte;
  logic [7:0]    w_b_byte;
  logic [7:0]    w_sum;
  logic          w_cout;
  logic          w_ovf;

  // Byte-slice mux feeding the shared adder.
  always_comb begin
    w_a_byte = r_a[{r_idx, 3'b000} +: BYTE_W];
    w_b_byte = r_b[{r_idx, 3'b000} +: BYTE_W];
  end

  add8bit u_add8bit (
    .i_a        (w_a_byte),
    .i_b        (w_b_byte),
    .i_cin      (r_carry),
    .o_sum      (w_sum),
    .o_cout     (w_cout),
    .o_overflow (w_ovf)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state, handshake outputs and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture on accept, then one result byte per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= op_a;
      r_b      <= sub ? ~op_b : op_b;
      r_carry  <= sub;
      r_idx    <= '0;
      r_result <= '0;
    end else if (w_step) begin
      r_result[{r_idx, 3'b000} +: BYTE_W] <= w_sum;
      r_carry <= w_cout;
      if (w_last) begin
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_idx  <= '0;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end
  end

  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule
